// File: rtl/dma_axil_regs_bridge_t_pkg.sv
// dma_axil_regs_bridge_t_pkg: DMA register map, AXI response codes and bridge FSM states
package dma_axil_regs_bridge_t_pkg;
  localparam logic [3:0] DMA_AXIS_AXI4_CTRL     = 4'h0;
  localparam logic [3:0] DMA_AXIS_AXI4_MIN_ADDR = 4'h1;
  localparam logic [3:0] DMA_AXIS_AXI4_FIFO_CNT = 4'h2;
  localparam logic [3:0] DMA_AXIS_AXI4_STATUS   = 4'h3;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ADDR, RD_CAP, RD_RESP} bridge_state_t;
endpackage

// File: rtl/dma_axil_regs_bridge_t.sv
// dma_axil_regs_bridge_t: AXI4-Lite slave driving the DMA register bus, with write timeout to SLVERR
module dma_axil_regs_bridge_t
  import dma_axil_regs_bridge_t_pkg::*;
#(
  parameter int REGS_DW        = 32,
  parameter int REGS_AW        = 4,
  parameter int AXI_AW         = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [AXI_AW-1:0]    s_axil_awaddr,
  input  logic                 s_axil_awvalid,
  output logic                 s_axil_awready,
  input  logic [REGS_DW-1:0]   s_axil_wdata,
  input  logic [REGS_DW/8-1:0] s_axil_wstrb,
  input  logic                 s_axil_wvalid,
  output logic                 s_axil_wready,
  output logic [1:0]           s_axil_bresp,
  output logic                 s_axil_bvalid,
  input  logic                 s_axil_bready,
  input  logic [AXI_AW-1:0]    s_axil_araddr,
  input  logic                 s_axil_arvalid,
  output logic                 s_axil_arready,
  output logic [REGS_DW-1:0]   s_axil_rdata,
  output logic [1:0]           s_axil_rresp,
  output logic                 s_axil_rvalid,
  input  logic                 s_axil_rready,
  output logic                 regs_we_o,
  output logic [REGS_AW-1:0]   regs_addr_o,
  output logic [REGS_DW-1:0]   regs_wdata_o,
  input  logic [REGS_DW-1:0]   regs_rdata_i,
  input  logic                 regs_rdy_i,
  output logic                 timeout_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  bridge_state_t state_q, state_d;
  logic wr_prio_q, timeout_q;
  logic [CW-1:0] cnt_q;
  logic [REGS_AW-1:0] addr_q;
  logic [REGS_DW-1:0] wdata_q, rdata_q;
  logic [1:0] bresp_q;
  logic grant_w, grant_r, strb_ok, stop, commit, expire, unused_addr;
  assign grant_w = state_q == IDLE && s_axil_awvalid && s_axil_wvalid && (!s_axil_arvalid || wr_prio_q);
  assign grant_r = state_q == IDLE && s_axil_arvalid && !grant_w;
  assign strb_ok = &s_axil_wstrb;
  // a stop request is accepted by the register block regardless of rdy
  assign stop = addr_q == REGS_AW'(DMA_AXIS_AXI4_CTRL) && wdata_q[1];
  assign commit = state_q == WR_ISSUE && (regs_rdy_i || stop);
  assign expire = state_q == WR_ISSUE && !commit && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign unused_addr = ^{s_axil_awaddr, s_axil_araddr};
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = grant_w ? (strb_ok ? WR_ISSUE : WR_RESP) : grant_r ? RD_ADDR : IDLE;
      WR_ISSUE: state_d = (commit || expire) ? WR_RESP : WR_ISSUE;
      WR_RESP:  state_d = s_axil_bready ? IDLE : WR_RESP;
      RD_ADDR:  state_d = RD_CAP;
      RD_CAP:   state_d = RD_RESP;
      RD_RESP:  state_d = s_axil_rready ? IDLE : RD_RESP;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      wr_prio_q <= 1'b1;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      state_q   <= state_d;
      timeout_q <= expire;
      cnt_q     <= state_q == WR_ISSUE ? cnt_q + 1'b1 : '0;
      if (grant_w || grant_r) begin
        addr_q    <= grant_w ? s_axil_awaddr[REGS_AW+1:2] : s_axil_araddr[REGS_AW+1:2];
        wr_prio_q <= grant_r;
      end
      if (grant_w) begin
        wdata_q <= s_axil_wdata;
        bresp_q <= strb_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
      if (expire) bresp_q <= AXI_RESP_SLVERR;
      if (state_q == RD_CAP) rdata_q <= regs_rdata_i;
    end
  end
  assign s_axil_awready = grant_w;
  assign s_axil_wready  = grant_w;
  assign s_axil_arready = grant_r;
  assign s_axil_bvalid  = state_q == WR_RESP;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = state_q == RD_RESP;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = AXI_RESP_OKAY;
  assign regs_we_o      = state_q == WR_ISSUE;
  assign regs_addr_o    = addr_q;
  assign regs_wdata_o   = wdata_q;
  assign timeout_o      = timeout_q;
endmodule

// File: tb/tb_dma_axil_regs_bridge_t.sv
// tb_dma_axil_regs_bridge_t: randomized transaction-level check of the AXI-Lite to register-bus bridge
module tb_dma_axil_regs_bridge_t;
  import dma_axil_regs_bridge_t_pkg::*;
  localparam int T = 16;
  logic aclk = 0, areset = 1;
  logic [11:0] awaddr = 0, araddr = 0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 0;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid, regs_we, regs_rdy, timeout;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata, regs_wdata, regs_rdata;
  logic [3:0] regs_addr;
  always #5 aclk = ~aclk;
  dma_axil_regs_bridge_t #(.REGS_DW(32), .REGS_AW(4), .AXI_AW(12), .TIMEOUT_CYCLES(T)) dut (
    .aclk(aclk), .areset(areset),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .regs_we_o(regs_we), .regs_addr_o(regs_addr), .regs_wdata_o(regs_wdata),
    .regs_rdata_i(regs_rdata), .regs_rdy_i(regs_rdy), .timeout_o(timeout)
  );
  // emulated DMA register block: rdy rises after rdy_delay cycles of we, read data one cycle late
  logic [31:0] mem [16] = '{default: '0};
  logic [31:0] model [16] = '{default: '0};
  int we_total = 0, to_total = 0, commits = 0, we_run = 0, rdy_delay = 0;
  logic [3:0] last_addr = 0;
  logic [31:0] last_data = 0, rdata_r = 0;
  bit scramble = 0;
  assign regs_rdy = we_run >= rdy_delay;
  assign regs_rdata = rdata_r;
  always @(posedge aclk) begin
    if (regs_we) begin
      we_total <= we_total + 1;
      we_run <= we_run + 1;
      last_addr <= regs_addr;
      last_data <= regs_wdata;
      if (regs_rdy || (regs_addr == DMA_AXIS_AXI4_CTRL && regs_wdata[1])) begin
        mem[regs_addr] <= regs_wdata;
        commits <= commits + 1;
      end
    end else we_run <= 0;
    if (timeout) to_total <= to_total + 1;
    rdata_r <= scramble ? ~mem[regs_addr] : mem[regs_addr];
  end
  int n_checks = 0, n_fail = 0;
  bit last_w = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] ba(input logic [3:0] w);
    return {6'($urandom), w, 2'($urandom)};
  endfunction
  task automatic wr_finish(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input int dly);
    int n, we0, to0, c0, exp_we, lat;
    logic [1:0] exp_resp;
    bit exp_to;
    logic [3:0] w;
    w = a[5:2];
    exp_to = 0;
    exp_resp = 2'b00;
    if (s != 4'hF) begin exp_we = 0; exp_resp = 2'b10; end
    else if (w == DMA_AXIS_AXI4_CTRL && d[1]) exp_we = 1;
    else if (dly < T) exp_we = dly + 1;
    else begin exp_we = T; exp_resp = 2'b10; exp_to = 1; end
    rdy_delay = dly;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge aclk); n++; end
    check("wr_grant", 32'(awready && wready), 1);
    we0 = we_total; to0 = to_total; c0 = commits;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0; last_w = 1;
    lat = 0;
    do begin @(negedge aclk); lat++; end while (!bvalid && lat < 100);
    check("b_latency", lat, exp_we + 1);
    check("bresp", 32'(bresp), 32'(exp_resp));
    @(posedge aclk); #1;
    check("we_cycles", we_total - we0, exp_we);
    check("commits", commits - c0, 32'(exp_resp == 2'b00 && exp_we > 0));
    check("timeout_pulses", to_total - to0, 32'(exp_to));
    check("bvalid_drop", 32'(bvalid), 0);
    if (exp_we > 0) begin
      check("we_addr", 32'(last_addr), 32'(w));
      check("we_data", last_data, d);
    end
    if (exp_resp == 2'b00) model[w] = d;
  endtask
  task automatic rd_finish(input logic [11:0] a, input int hold);
    int n, lat;
    logic [31:0] exp;
    exp = model[a[5:2]];
    n = 0;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    check("rd_grant", 32'(arready), 1);
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0; last_w = 0;
    lat = 0;
    do begin @(negedge aclk); lat++; end while (!rvalid && lat < 20);
    check("r_latency", lat, 3);
    check("rdata", rdata, exp);
    check("rresp", 32'(rresp), 0);
    scramble = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check("r_hold_valid", 32'(rvalid), 1);
      check("r_hold_data", rdata, exp);
    end
    scramble = 0;
    rready = 1;
    @(posedge aclk); #1;
    rready = 0;
    check("rvalid_drop", 32'(rvalid), 0);
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input int dly);
    @(posedge aclk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    @(negedge aclk);
    wr_finish(a, d, s, dly);
  endtask
  task automatic rd(input logic [11:0] a, input int hold);
    @(posedge aclk); #1;
    araddr = a; arvalid = 1;
    @(negedge aclk);
    rd_finish(a, hold);
  endtask
  task automatic contest();
    bit exp_w;
    logic [31:0] d;
    exp_w = !last_w;
    d = $urandom;
    @(posedge aclk); #1;
    awaddr = ba(4'($urandom_range(1, 15))); wdata = d; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = ba(4'($urandom)); arvalid = 1;
    @(negedge aclk);
    check("arb_aw", 32'(awready), 32'(exp_w));
    check("arb_ar", 32'(arready), 32'(!exp_w));
    if (awready) wr_finish(awaddr, d, 4'hF, 0);
    else rd_finish(araddr, 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0] s;
    int dly;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", 32'(awready), 0);
    check("rst_wready", 32'(wready), 0);
    check("rst_arready", 32'(arready), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_we", 32'(regs_we), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_bresp", 32'(bresp), 0);
    check("rst_rresp", 32'(rresp), 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", 32'(regs_addr), 0);
    check("rst_wdata", regs_wdata, 0);
    areset = 0;
    wr(ba(DMA_AXIS_AXI4_MIN_ADDR), 32'h1000, 4'hF, 0);
    wr(ba(DMA_AXIS_AXI4_MIN_ADDR), 32'h1111, 4'hF, 10);
    wr(ba(4'h4), 32'h4444, 4'hF, 15);
    wr(ba(4'h3), 32'h3333, 4'hF, 16);
    wr(ba(4'h5), 32'h5555, 4'hF, 30);
    wr(ba(DMA_AXIS_AXI4_CTRL), 32'h2, 4'hF, 1000);
    wr(ba(DMA_AXIS_AXI4_CTRL), 32'h1, 4'hF, 5);
    wr(ba(DMA_AXIS_AXI4_CTRL), 32'h1, 4'hF, 1000);
    wr(ba(DMA_AXIS_AXI4_FIFO_CNT), 32'hABCD, 4'hF, 0);
    rd(ba(DMA_AXIS_AXI4_FIFO_CNT), 5);
    wr(ba(DMA_AXIS_AXI4_FIFO_CNT), 32'h9999, 4'h3, 0);
    rd(ba(DMA_AXIS_AXI4_FIFO_CNT), 1);
    rd(ba(4'h3), 0);
    rd(ba(4'h4), 2);
    repeat (4) contest();
    wr(ba(4'h6), 32'h6666, 4'hF, 0);
    @(posedge aclk); #1;
    awaddr = ba(4'h6); wdata = 32'hDEAD; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    rdy_delay = 1000;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    @(posedge aclk); #1;
    check("we_before_reset", 32'(regs_we), 1);
    areset = 1;
    @(posedge aclk); #1;
    check("abort_we", 32'(regs_we), 0);
    check("abort_bvalid", 32'(bvalid), 0);
    check("abort_addr", 32'(regs_addr), 0);
    check("abort_wdata", regs_wdata, 0);
    areset = 0;
    last_w = 0;
    repeat (4) @(posedge aclk);
    #1;
    check("abort_no_resp", 32'(bvalid), 0);
    rd(ba(4'h6), 0);
    wr(ba(4'h7), 32'h7777, 4'hF, 2);
    rd(ba(4'h7), 1);
    for (int i = 0; i < 40; i++) begin
      a = ba(4'($urandom));
      d = $urandom;
      s = $urandom_range(0, 7) == 0 ? 4'($urandom) : 4'hF;
      dly = $urandom_range(0, 5) == 0 ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) wr(a, d, s, dly);
      else rd(a, $urandom_range(0, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
